// File: rtl/cdb_arbiter_if.sv
// Result-bus interface between the functional-unit result ports and the CDB arbiter.
// master: the requester side (drives results, observes ready and the broadcast).
// slave:  the arbiter side.
interface cdb_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int TAG_W       = 6,
  parameter int STALL_CNT_W = 16
);
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      val;
  } cdb_t;

  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag_i;
  logic [NUM_REQ-1:0][31:0]       req_val_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  cdb_t                           cdb_o;
  logic                           cdb_busy_o;
  logic [STALL_CNT_W-1:0]         stall_cnt_o;

  modport master (
    output req_valid_i, req_tag_i, req_val_i,
    input  req_ready_o, cdb_o, cdb_busy_o, stall_cnt_o
  );

  modport slave (
    input  req_valid_i, req_tag_i, req_val_i,
    output req_ready_o, cdb_o, cdb_busy_o, stall_cnt_o
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus. One result per cycle is accepted
// and broadcast on the following cycle; a saturating counter tracks cycles with
// more than one pending result.
//
// state     | meaning
// IDLE      | no requester valid; cdb_o returns to NO_VAL, ptr holds
// ARBITRATE | >=1 requester valid; first valid from ptr wins, ptr moves past it
// (the state is implicit in req_valid_i; stored state is ptr, cdb_o, stall count)
module cdb_arbiter #(
  parameter int               NUM_REQ     = 4,
  parameter int               TAG_W       = 6,
  parameter int               STALL_CNT_W = 16,
  parameter logic [TAG_W-1:0] NO_VAL      = '0
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      val;
  } cdb_t;

  logic [PTR_W-1:0]       ptr_q, ptr_d;
  cdb_t                   cdb_q, cdb_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic                   gnt_vld;
  logic [PTR_W-1:0]       gnt_idx;
  logic [PTR_W:0]         cand;
  logic [NUM_REQ-1:0]     req_ready;
  logic [TAG_W-1:0]       win_tag;
  logic [31:0]            win_val;
  logic                   contention;

  // Rotating priority search; iterating from the far end lets the closest
  // valid requester to ptr overwrite any later one.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (bus.req_valid_i[cand[PTR_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[PTR_W-1:0];
      end
    end
  end

  // Ready depends only on valid and ptr; gated off while reset is asserted so
  // nothing can be accepted and then lost.
  always_comb begin
    req_ready = '0;
    if (reset_ni && gnt_vld) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign win_tag    = bus.req_tag_i[gnt_idx];
  assign win_val    = bus.req_val_i[gnt_idx];
  assign contention = $countones(bus.req_valid_i) > 1;

  // Next-state: pointer moves past the winner, broadcast is one cycle only,
  // and a NO_VAL-tagged result is drained without being broadcast.
  always_comb begin
    ptr_d   = ptr_q;
    cdb_d   = '{tag: NO_VAL, val: '0};
    stall_d = stall_q;
    if (gnt_vld) begin
      ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      if (win_tag != NO_VAL) begin
        cdb_d = '{tag: win_tag, val: win_val};
      end
    end
    if (contention && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr_q   <= '0;
      cdb_q   <= '{tag: NO_VAL, val: '0};
      stall_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      cdb_q   <= cdb_d;
      stall_q <= stall_d;
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.cdb_o       = cdb_q;
  assign bus.cdb_busy_o  = (cdb_q.tag != NO_VAL);
  assign bus.stall_cnt_o = stall_q;

  // A requester presenting the NO_VAL tag is a producer bug; flag it when it wins.
  novaltag_a: assert property (@(posedge clk_i) disable iff (!reset_ni)
                               !(gnt_vld && (win_tag == NO_VAL)))
    else $warning("cdb_arbiter: requester %0d presented the NO_VAL tag", gnt_idx);

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among the functional-unit result ports of the out-of-order core. Each cycle it selects at most one pending result, acknowledges that requester, and drives the winning tag/value onto a registered `cdb_t` output. That output feeds the register file, the reservation stations and the other CDB snoopers. It also exports a busy flag and a saturating contention counter for performance monitoring.

## Interface
Parameters:
- `NUM_REQ`, 4: number of result producers (≥2); pointer width is `$clog2(NUM_REQ)`.
- `STALL_CNT_W`, 16: width of the contention counter.

Ports:
- `clk_i` in 1: single clock; all state updates on its rising edge.
- `reset_ni` in 1: asynchronous, active-low reset.
- `req_valid_i` in `NUM_REQ`: requester i holds a result.
- `req_tag_i` in `NUM_REQ` x `rs_tag_t`: tag of requester i's result.
- `req_val_i` in `NUM_REQ` x `word32_t`: value of requester i's result.
- `req_ready_o` out `NUM_REQ`: one-hot or zero; requester i's result is accepted this cycle.
- `cdb_o` out `cdb_t`: registered broadcast (`tag`, `val`).
- `cdb_busy_o` out 1: `cdb_o.tag != NO_VAL`.
- `stall_cnt_o` out `STALL_CNT_W`: saturating count of contention cycles.

## Operation
- Handshake is valid/ready. A transfer occurs when `req_valid_i[i] & req_ready_o[i]`. Requesters hold valid, tag and value stable until accepted. Valid is never withdrawn before acceptance.
- `req_ready_o` is combinational from `req_valid_i` and the priority pointer `ptr`. No combinational path from tag or value to ready is allowed.
- Grant search order: ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1, modulo NUM_REQ. The first valid requester in that order wins. At most one ready bit is high.
- After a grant to index g, `ptr <= (g+1) mod NUM_REQ`. With no grant, ptr holds.
- Winning tag/value are registered into `cdb_o` at the same edge. With no grant, `cdb_o.tag <= NO_VAL` and `cdb_o.val <= '0`. A broadcast therefore lasts exactly one cycle and never repeats.
- Valid with tag == NO_VAL is a protocol violation. It is still arbitrated and accepted, so the requester drains. Its broadcast is suppressed: `cdb_o.tag = NO_VAL`, val = 0. Add an assertion for this case.
- Contention: if more than one requester is valid in a cycle, `stall_cnt_o` increments by 1 at the edge. It saturates at all-ones.
- The state machine is implicit: IDLE (no valid) ⇄ ARBITRATE (≥1 valid). The only state is `ptr`, `cdb_o` and `stall_cnt_o`.

## Timing
- Reset asserted (async, immediate):
  - `cdb_o.tag = NO_VAL`, `cdb_o.val = 0`
  - `cdb_busy_o = 0`, `stall_cnt_o = 0`, `ptr = 0`
  - `req_ready_o = 0` for the whole time reset_ni is low, so no transfer can occur during reset.
- Reset released: the first grant is possible in the first cycle with reset_ni high. A result accepted in cycle N appears on `cdb_o` in cycle N+1.
- Throughput: one broadcast per cycle. Back-to-back grants to different or same requesters are allowed.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles of first asserting valid.
- Pointer wrap: a grant to NUM_REQ-1 sets ptr = 0.
- Reset mid-operation: any result accepted in the last cycle before reset is lost. `cdb_o` is cleared asynchronously. Requesters must also be reset; no replay is performed.

## Test plan
- Reset: hold reset_ni=0 with all `req_valid_i`=1 → `req_ready_o`=0, `cdb_o.tag`=NO_VAL, `stall_cnt_o`=0. Deassert → cycle 0 grants req0; cycle 1 `cdb_o` = req0's tag/value.
- Single requester: req2 valid, tag 5, val 0xDEADBEEF for 3 consecutive results (new tag each accept) → ready2 every cycle; cdb tags 5,6,7 on successive cycles; `stall_cnt_o` stays 0.
- All 4 requesters valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; `stall_cnt_o` = 8; every broadcast lasts one cycle.
- Pointer and wrap: grant req3 (ptr→0), then req1 and req3 valid → req1 granted, ptr=2; next cycle req3 granted, ptr=0.
- NO_VAL request: req1 valid with tag NO_VAL → ready1=1; next cycle `cdb_o.tag`=NO_VAL, val=0, `cdb_busy_o`=0; the assertion fires.
- Async reset mid-stream: drop reset_ni between clock edges while `cdb_o` is busy → `cdb_o.tag`=NO_VAL before the next edge; `stall_cnt_o`=0. Also force `stall_cnt_o` to 0xFFFE under contention → it reaches 0xFFFF and stays there.
